// File: rtl/zeroheti_sys_ctrl.sv
// Reset sequencer: holds all domains in reset, then releases them one at a time
// in ascending order, waiting for each domain's acknowledge or a timeout.
module zeroheti_sys_ctrl #(
  parameter int unsigned NumDomains    = 2,
  parameter int unsigned RstCycles     = 16,
  parameter int unsigned TimeoutCycles = 64,
  parameter logic [NumDomains-1:0] KeepMask = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  testmode_i,
  input  logic                  ndmreset_req_i,
  input  logic                  sw_rst_req_i,
  input  logic [NumDomains-1:0] domain_ack_i,
  output logic [NumDomains-1:0] domain_rst_no,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [NumDomains-1:0] fail_mask_o
);

  localparam int unsigned KW        = (NumDomains > 1) ? $clog2(NumDomains) : 1;
  localparam int unsigned MaxCycles = (RstCycles > TimeoutCycles) ? RstCycles : TimeoutCycles;
  localparam int unsigned CW        = $clog2(MaxCycles + 1);

  typedef enum logic [1:0] {HOLD, WAIT, RUN} state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NumDomains-1:0] rel_q, rel_d;
  logic [NumDomains-1:0] skip_q, skip_d;
  logic [NumDomains-1:0] fail_q, fail_d;
  logic                  timeout_q, timeout_d;
  logic                  busy_q;
  logic                  req;
  logic                  advance;
  logic                  found_first, found_next;
  logic [KW-1:0]         first_idx, next_idx;

  assign req = ndmreset_req_i | sw_rst_req_i;

  // Lowest sequenced domain overall, and the next sequenced domain above k.
  always_comb begin
    found_first = 1'b0;
    first_idx   = '0;
    found_next  = 1'b0;
    next_idx    = '0;
    for (int unsigned i = 0; i < NumDomains; i++) begin
      if (!skip_q[i] && !found_first) begin
        found_first = 1'b1;
        first_idx   = KW'(i);
      end
      if (!skip_q[i] && !found_next && (KW'(i) > k_q)) begin
        found_next = 1'b1;
        next_idx   = KW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    skip_d    = skip_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    advance   = 1'b0;
    if (req) begin
      // Exempt domains that are already running are left alone and skipped;
      // an exempt domain still in reset is sequenced normally.
      state_d   = HOLD;
      k_d       = '0;
      cnt_d     = '0;
      rel_d     = rel_q & KeepMask;
      skip_d    = rel_q & KeepMask;
      fail_d    = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CW'(RstCycles - 1)) begin
            cnt_d = '0;
            if (found_first) begin
              state_d          = WAIT;
              k_d              = first_idx;
              rel_d[first_idx] = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT: begin
          if (domain_ack_i[k_q]) begin
            advance = 1'b1;
          end else if (cnt_q == CW'(TimeoutCycles - 1)) begin
            advance     = 1'b1;
            fail_d[k_q] = 1'b1;
            timeout_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          if (advance) begin
            cnt_d = '0;
            if (found_next) begin
              k_d             = next_idx;
              rel_d[next_idx] = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= HOLD;
      k_q       <= '0;
      cnt_q     <= '0;
      rel_q     <= '0;
      skip_q    <= '0;
      fail_q    <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      skip_q    <= skip_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d != RUN);
    end
  end

  assign domain_rst_no = testmode_i ? {NumDomains{~rst_i}} : rel_q;
  assign busy_o        = busy_q;
  assign timeout_o     = timeout_q;
  assign fail_mask_o   = fail_q;

endmodule

// File: tb/tb_zeroheti_sys_ctrl.sv
// Scoreboard bench for zeroheti_sys_ctrl: a pending-list reference model queues the
// expected outputs each cycle and a monitor compares them on the falling edge.
module tb_zeroheti_sys_ctrl;

  localparam int N   = 3;
  localparam int RST = 4;
  localparam int TO  = 8;
  localparam logic [N-1:0] KEEP = 3'b001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tm  = 1'b0;
  logic         ndm = 1'b0;
  logic         sw  = 1'b0;
  logic [N-1:0] domain_ack = '0;
  logic [N-1:0] domain_rst_no;
  logic         busy;
  logic         timeout;
  logic [N-1:0] fail_mask;

  int checks   = 0;
  int failures = 0;

  zeroheti_sys_ctrl #(
    .NumDomains(N),
    .RstCycles(RST),
    .TimeoutCycles(TO),
    .KeepMask(KEEP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .testmode_i(tm),
    .ndmreset_req_i(ndm),
    .sw_rst_req_i(sw),
    .domain_ack_i(domain_ack),
    .domain_rst_no(domain_rst_no),
    .busy_o(busy),
    .timeout_o(timeout),
    .fail_mask_o(fail_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Domain behaviour: ack rises 'lat' cycles after release unless stuck.
  int age_a[N] = '{default: 0};
  int lat[N]   = '{default: 2};
  bit stuck[N] = '{default: 1'b0};
  bit rand_mode = 1'b0;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (domain_rst_no[i]) begin
        age_a[i]++;
        domain_ack[i] = !stuck[i] && (age_a[i] > lat[i]);
      end else begin
        age_a[i]      = 0;
        lat[i]        = rand_mode ? int'($urandom_range(0, 10)) : 2;
        domain_ack[i] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Reference model: remaining hold cycles plus an ordered list of domains still to release.
  typedef struct packed {
    logic [N-1:0] rel;
    logic         busy;
    logic         to;
    logic [N-1:0] fail;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] m_rel, m_fail;
  logic         m_to;
  int           m_hold, m_age;
  int           m_pend[$];

  task automatic m_init();
    m_rel  = '0;
    m_fail = '0;
    m_to   = 1'b0;
    m_hold = RST;
    m_age  = 0;
    m_pend.delete();
    for (int i = 0; i < N; i++) m_pend.push_back(i);
  endtask

  task automatic m_step(input logic req, input logic [N-1:0] ack);
    int  f;
    bit  adv;
    if (req) begin
      m_pend.delete();
      for (int i = 0; i < N; i++)
        if (!(KEEP[i] && m_rel[i])) m_pend.push_back(i);
      m_rel  = m_rel & KEEP;
      m_hold = RST;
      m_fail = '0;
      m_to   = 1'b0;
      m_age  = 0;
    end else if (m_hold > 0) begin
      m_hold--;
      m_age = 0;
      if (m_hold == 0 && m_pend.size() > 0) m_rel[m_pend[0]] = 1'b1;
    end else if (m_pend.size() > 0) begin
      f   = m_pend[0];
      adv = 1'b0;
      if (ack[f]) adv = 1'b1;
      else if (m_age == TO - 1) begin
        adv       = 1'b1;
        m_fail[f] = 1'b1;
        m_to      = 1'b1;
      end else m_age++;
      if (adv) begin
        void'(m_pend.pop_front());
        m_age = 0;
        if (m_pend.size() > 0) m_rel[m_pend[0]] = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (rst) m_init();
    else m_step(ndm | sw, domain_ack);
    e.rel  = m_rel;
    e.busy = (m_hold > 0) || (m_pend.size() > 0);
    e.to   = m_to;
    e.fail = m_fail;
    sb.push_back(e);
  end

  always @(posedge rst) begin
    m_init();
    sb.delete();
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("domain_rst_no", 32'(domain_rst_no), 32'(tm ? {N{~rst}} : e.rel));
      check("busy_o", 32'(busy), 32'(e.busy));
      check("timeout_o", 32'(timeout), 32'(e.to));
      check("fail_mask_o", 32'(fail_mask), 32'(e.fail));
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'(0));
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic sw_pulse();
    @(negedge clk);
    #1 sw = 1'b1;
    @(negedge clk);
    #1 sw = 1'b0;
  endtask

  initial begin
    int n;
    int ndm_left;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    wait_idle("powerup_idle");

    // Asynchronous reset while waiting on domain 1
    pulse_rst();
    n = 0;
    while (!(domain_rst_no === 3'b011 && busy === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait1", 32'(domain_rst_no), 32'(3'b011));
    #2 rst = 1'b1;
    #1 check("async_abort", 32'(domain_rst_no), 32'(3'b000));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    wait_idle("restart_idle");

    // Timeout on domain 1
    stuck[1] = 1'b1;
    pulse_rst();
    wait_idle("timeout_idle");
    check("timeout_fail_mask", 32'(fail_mask), 32'(3'b010));
    check("timeout_flag", 32'(timeout), 32'(1));
    stuck[1] = 1'b0;

    // Software reset with domain 0 exempt
    sw_pulse();
    check("sw_keep_rst_no", 32'(domain_rst_no), 32'(3'b001));
    check("sw_fail_cleared", 32'(fail_mask), 32'(0));
    wait_idle("sw_idle");

    // Level debug reset held for 10 cycles
    @(negedge clk);
    #1 ndm = 1'b1;
    repeat (10) @(negedge clk);
    #1 ndm = 1'b0;
    wait_idle("ndm_idle");

    // Request coincident with domain 1 acknowledge
    sw_pulse();
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #2;
      if (domain_ack[1] && domain_rst_no === 3'b011 && busy) break;
      n++;
    end
    check("coincident_setup", 32'(domain_ack[1]), 32'(1));
    sw = 1'b1;
    @(posedge clk);
    #2 sw = 1'b0;
    check("req_wins_ack", 32'(domain_rst_no), 32'(3'b001));
    wait_idle("coincident_idle");

    // Scan bypass follows reset without a clock edge
    @(negedge clk);
    #1 tm = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("tm_rst_high", 32'(domain_rst_no), 32'(3'b000));
    #1 rst = 1'b0;
    #1 check("tm_rst_low", 32'(domain_rst_no), 32'(3'b111));
    repeat (3) @(negedge clk);
    #1 tm = 1'b0;
    wait_idle("tm_idle");

    // Randomized traffic
    rand_mode = 1'b1;
    ndm_left  = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      #1;
      sw = ($urandom_range(0, 39) == 0);
      if (ndm_left > 0) begin
        ndm = 1'b1;
        ndm_left--;
      end else begin
        ndm = 1'b0;
        if ($urandom_range(0, 79) == 0) ndm_left = int'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 99) == 0) begin
        n = int'($urandom_range(0, N - 1));
        stuck[n] = !stuck[n];
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
    end
    @(negedge clk);
    #1;
    sw  = 1'b0;
    ndm = 1'b0;
    rst = 1'b0;
    rand_mode = 1'b0;
    for (int i = 0; i < N; i++) stuck[i] = 1'b0;
    wait_idle("final_idle");
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
